// File: rtl/partial_sum_accumulator_pkg.sv
// Shared types, reset values and the sum-narrowing function for partial_sum_accumulator.
// The function serves any DATA_WIDTH/ACC_WIDTH pair up to SAT_MAX_W bits.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  localparam int SAT_MAX_W = 128;

  localparam acc_state_t RST_STATE   = IDLE;
  localparam logic       RST_OUT_SAT = 1'b0;

  typedef struct packed {
    logic                        sat;
    logic signed [SAT_MAX_W-1:0] value;
  } sat_result_t;

  // Caller sign-extends its sum to SAT_MAX_W and keeps the low data_w bits of value.
  function automatic sat_result_t sat_narrow(input logic signed [SAT_MAX_W-1:0] v,
                                             input int data_w,
                                             input bit sat_en);
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (SAT_MAX_W'(1) << (data_w - 1)) - SAT_MAX_W'(1);
    lo = ~hi;
    sat_narrow.sat   = 1'b0;
    sat_narrow.value = v;
    if (sat_en && (v > hi)) begin
      sat_narrow.sat   = 1'b1;
      sat_narrow.value = hi;
    end else if (sat_en && (v < lo)) begin
      sat_narrow.sat   = 1'b1;
      sat_narrow.value = lo;
    end
  endfunction

endpackage

// File: rtl/partial_sum_accumulator_if.sv
// Upstream partial-sum stream and downstream result stream of partial_sum_accumulator.
// master = producer/consumer side, slave = the accumulator.
interface partial_sum_accumulator_if #(
  parameter int DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] bias;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_sat;

  modport master (
    output bias, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  bias, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/partial_sum_accumulator_saturate.sv
// Combinational ACC_WIDTH -> DATA_WIDTH narrowing of the final sum.
// ACC_SATURATE_EN defined: clamp to the signed range and flag it; undefined: plain wrap.
module acc_saturate
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40
) (
  input  logic signed [ACC_WIDTH-1:0]  sum,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         sat
);

`ifdef ACC_SATURATE_EN
  sat_result_t narrowed;

  always_comb begin
    narrowed = sat_narrow(SAT_MAX_W'(sum), DATA_WIDTH, 1'b1);
    result   = DATA_WIDTH'(narrowed.value);
    sat      = narrowed.sat;
  end
`else
  assign result = DATA_WIDTH'(sum);
  assign sat    = 1'b0;
`endif

endmodule

// File: rtl/partial_sum_accumulator.sv
// Adds a bias to NUM_CHUNKS consecutive partial sums and hands the result out through a
// valid/ready register stage. Build option: ACC_SATURATE_EN (clamp instead of wrap).
//
//   state | meaning
//   IDLE  | count = 0, nothing pending
//   ACCUM | 0 < count < NUM_CHUNKS, partial sum held in acc
//   HOLD  | result registered, waiting for out_ready
module partial_sum_accumulator
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int NUM_CHUNKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic busy,
  partial_sum_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_CHUNKS + 1);

  acc_state_t                  state, state_n;
  logic signed [ACC_WIDTH-1:0] acc, acc_n, sum;
  logic [CNT_W-1:0]            count, count_n;
  logic                        accept, last, load_out;
  logic signed [DATA_WIDTH-1:0] res;
  logic                        res_sat;

  // Chunk 0 starts from the bias instead of the stale accumulator.
  always_comb begin
    bus.in_ready = (state == HOLD) ? bus.out_ready : 1'b1;
    accept       = bus.in_valid && bus.in_ready;
    last         = (count == CNT_W'(NUM_CHUNKS - 1));
    sum          = ((count == '0) ? ACC_WIDTH'(bus.bias) : acc) + ACC_WIDTH'(bus.in_data);
    state_n      = state;
    acc_n        = acc;
    count_n      = count;
    load_out     = 1'b0;
    if (clear) begin
      state_n = IDLE;
      count_n = '0;
    end else if (accept) begin
      if (last) begin
        load_out = 1'b1;
        count_n  = '0;
        state_n  = HOLD;
      end else begin
        acc_n   = sum;
        count_n = count + 1'b1;
        state_n = ACCUM;
      end
    end else if ((state == HOLD) && bus.out_ready) begin
      state_n = IDLE;
    end
  end

  acc_saturate #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_saturate (
    .sum   (sum),
    .result(res),
    .sat   (res_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RST_STATE;
      acc          <= '0;
      count        <= '0;
      bus.out_data <= '0;
      bus.out_sat  <= RST_OUT_SAT;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      count <= count_n;
      if (load_out) begin
        bus.out_data <= res;
        bus.out_sat  <= res_sat;
      end
    end
  end

  assign bus.out_valid = (state == HOLD);
  assign busy          = (count != '0);

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Directed bench for partial_sum_accumulator: a NUM_CHUNKS=4 instance and a NUM_CHUNKS=1 instance.
module tb_partial_sum_accumulator;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic clear, clear1;
  logic busy, busy1;
  int   n_checks = 0;
  int   n_pass   = 0;

  partial_sum_accumulator_if #(.DATA_WIDTH(DW)) bus  ();
  partial_sum_accumulator_if #(.DATA_WIDTH(DW)) bus1 ();

  partial_sum_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(40), .NUM_CHUNKS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy), .bus(bus)
  );

  partial_sum_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(40), .NUM_CHUNKS(1)) u_one (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .busy(busy1), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic signed [DW-1:0] b, input logic signed [DW-1:0] c0,
                      input logic signed [DW-1:0] c1, input logic signed [DW-1:0] c2,
                      input logic signed [DW-1:0] c3);
    logic signed [DW-1:0] c [4];
    c = '{c0, c1, c2, c3};
    bus.bias = b;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = c[i];
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0; clear1 = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.bias = '0; bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.bias = '0; bus1.out_ready = 1'b1;
    step(); step();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 32'sd0) $display("FAIL rst_out_data: got %0d expected 0", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_sat !== 1'b0) $display("FAIL rst_out_sat: got %b expected 0", bus.out_sat); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (bus1.out_valid !== 1'b0) $display("FAIL rst_one_out_valid: got %b expected 0", bus1.out_valid); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    bus.bias = 32'sd10;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(i + 1);
      step();
      if (i == 0) begin
        n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy); else n_pass++;
      end
      if (i == 2) begin
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", bus.out_valid); else n_pass++;
      end
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 32'sd20) $display("FAIL basic_data: got %0d expected 20", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_sat !== 1'b0) $display("FAIL basic_sat: got %b expected 0", bus.out_sat); else n_pass++;
    step();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_one_cycle: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    feed(32'sd10, 32'sd1, 32'sd2, 32'sd3, 32'sd4);
    bus.bias = 32'sd0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'sd7;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_data !== 32'sd20) $display("FAIL bp_data[%0d]: got %0d expected 20", i, bus.out_data); else n_pass++;
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); else n_pass++;
    step();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_taken: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL bp_chunk0_accepted: got %b expected 1", busy); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 32'sd1;
      step();
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_second_valid: got %b expected 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 32'sd10) $display("FAIL bp_second_data: got %0d expected 10", bus.out_data); else n_pass++;
    step();
  endtask

  task automatic test_negative();
    bus.out_ready = 1'b1;
    feed(-32'sd100, -32'sd1, -32'sd2, -32'sd3, 32'sd50);
    n_checks++; if (bus.out_data !== -32'sd56) $display("FAIL neg_data: got %0d expected -56", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_sat !== 1'b0) $display("FAIL neg_sat: got %b expected 0", bus.out_sat); else n_pass++;
    step();
  endtask

  task automatic test_saturation();
    logic [DW-1:0] exp_hi, exp_lo;
    logic          exp_sat;
`ifdef ACC_SATURATE_EN
    exp_hi = 32'h7FFF_FFFF; exp_lo = 32'h8000_0000; exp_sat = 1'b1;
`else
    exp_hi = 32'h8000_0000; exp_lo = 32'h7FFF_FFFF; exp_sat = 1'b0;
`endif
    bus.out_ready = 1'b1;
    feed(32'sh7FFF_FFFF, 32'sd1, 32'sd0, 32'sd0, 32'sd0);
    n_checks++; if (bus.out_data !== exp_hi) $display("FAIL sat_pos_data: got %h expected %h", bus.out_data, exp_hi); else n_pass++;
    n_checks++; if (bus.out_sat !== exp_sat) $display("FAIL sat_pos_flag: got %b expected %b", bus.out_sat, exp_sat); else n_pass++;
    step();
    feed(32'sh8000_0000, -32'sd1, 32'sd0, 32'sd0, 32'sd0);
    n_checks++; if (bus.out_data !== exp_lo) $display("FAIL sat_neg_data: got %h expected %h", bus.out_data, exp_lo); else n_pass++;
    n_checks++; if (bus.out_sat !== exp_sat) $display("FAIL sat_neg_flag: got %b expected %b", bus.out_sat, exp_sat); else n_pass++;
    step();
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b1;
    bus.bias = 32'sd1;
    bus.in_valid = 1'b1; bus.in_data = 32'sd2;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    n_checks++; if (busy !== 1'b1) $display("FAIL stall_busy: got %b expected 1", busy); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL stall_valid: got %b expected 0", bus.out_valid); else n_pass++;
    for (int i = 3; i <= 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(i);
      step();
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_data !== 32'sd15) $display("FAIL stall_data: got %0d expected 15", bus.out_data); else n_pass++;
    step();
  endtask

  task automatic test_clear();
    bus.out_ready = 1'b1;
    bus.bias = 32'sd0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'sd9;
      step();
    end
    clear = 1'b1;
    step();
    clear = 1'b0; bus.in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL clear_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL clear_valid: got %b expected 0", bus.out_valid); else n_pass++;
    feed(32'sd0, 32'sd5, 32'sd5, 32'sd5, 32'sd5);
    n_checks++; if (bus.out_data !== 32'sd20) $display("FAIL clear_residue: got %0d expected 20", bus.out_data); else n_pass++;
    step();
    bus.out_ready = 1'b0;
    feed(32'sd0, 32'sd1, 32'sd1, 32'sd1, 32'sd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL clear_hold_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL clear_hold_ready: got %b expected 1", bus.in_ready); else n_pass++;
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    feed(32'sd0, 32'sd2, 32'sd2, 32'sd2, 32'sd2);
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL areset_pre_valid: got %b expected 1", bus.out_valid); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL areset_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL areset_ready: got %b expected 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_data !== 32'sd0) $display("FAIL areset_data: got %0d expected 0", bus.out_data); else n_pass++;
    #2;
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    feed(32'sd0, 32'sd1, 32'sd1, 32'sd1, 32'sd1);
    n_checks++; if (bus.out_data !== 32'sd4) $display("FAIL areset_residue: got %0d expected 4", bus.out_data); else n_pass++;
    step();
  endtask

  task automatic test_single_chunk();
    int vs  [4] = '{5, -3, 100, 0};
    int bs  [4] = '{1, 10, -200, 0};
    int exp [4] = '{6, 7, -100, 0};
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus1.in_valid = 1'b1; bus1.in_data = DW'(vs[i]); bus1.bias = DW'(bs[i]);
      step();
      n_checks++; if (bus1.out_valid !== 1'b1) $display("FAIL one_valid[%0d]: got %b expected 1", i, bus1.out_valid); else n_pass++;
      n_checks++; if (bus1.out_data !== DW'(exp[i])) $display("FAIL one_data[%0d]: got %0d expected %0d", i, bus1.out_data, exp[i]); else n_pass++;
    end
    bus1.out_ready = 1'b0;
    bus1.in_data = 32'sd1; bus1.bias = 32'sd1;
    step();
    n_checks++; if (bus1.out_data !== 32'sd0) $display("FAIL one_hold_data: got %0d expected 0", bus1.out_data); else n_pass++;
    n_checks++; if (bus1.in_ready !== 1'b0) $display("FAIL one_hold_ready: got %b expected 0", bus1.in_ready); else n_pass++;
    bus1.out_ready = 1'b1;
    step();
    n_checks++; if (bus1.out_data !== 32'sd2) $display("FAIL one_release_data: got %0d expected 2", bus1.out_data); else n_pass++;
    bus1.in_valid = 1'b0;
    step();
    n_checks++; if (bus1.out_valid !== 1'b0) $display("FAIL one_drain: got %b expected 0", bus1.out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_negative();
    test_saturation();
    test_stall();
    test_clear();
    test_async_reset();
    test_single_chunk();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
